mem_port_arbiter: RTL

//  Two-port arbiter/sequencer in front of the single-port 8 x 256-bit RAM ("memory").

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-port round-robin arbiter/sequencer in front of a single-port RAM.
//   Port 0 (scalar core) and port 1 (matrix engine) issue valid/ready
//   requests. The winner's request is latched into the RAM control pins,
//   and the read data or write ack comes back as a 1-cycle pulse on that
//   port only.
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   reqN_valid/rw/addr/wdata      request from port N (rw: 1=read, 0=write)
//   reqN_ready                    request accepted at the edge when valid&ready
//   rspN_valid, rspN_rdata        response pulse; rdata held between reads
//   mem_nEnable, mem_ReadWrite    RAM enable (active low), direction (1=read)
//   mem_addr, mem_wdata, mem_oe   RAM address, write data, bus output enable
//   mem_rdata                     sampled RAM data bus
module mem_port_arbiter #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_nEnable,
  output logic              mem_ReadWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

  state_t state;
  logic   lastGrant;   // port served most recently; the other wins a tie
  logic   curPort;     // port owning the access in flight
  logic   grant0, grant1;

  // At most one grant can be high: on a tie lastGrant picks exactly one.
  assign grant0 = req0_valid && (!req1_valid || lastGrant);
  assign grant1 = req1_valid && (!req0_valid || !lastGrant);

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lastGrant     <= 1'b1;
      curPort       <= 1'b0;
      mem_nEnable   <= 1'b1;
      mem_ReadWrite <= 1'b1;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_oe        <= 1'b0;
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp0_rdata    <= '0;
      rsp1_rdata    <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            curPort       <= grant1;
            lastGrant     <= grant1;
            mem_ReadWrite <= grant1 ? req1_rw    : req0_rw;
            mem_addr      <= grant1 ? req1_addr  : req0_addr;
            mem_wdata     <= grant1 ? req1_wdata : req0_wdata;
            // Bus is driven only for writes; reads leave it to the RAM.
            mem_oe        <= grant1 ? !req1_rw   : !req0_rw;
            mem_nEnable   <= 1'b0;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ReadWrite) begin
            state <= CAPTURE;
          end else begin
            // Write completed by the RAM at this edge: release the bus and
            // park the direction at read.
            mem_nEnable   <= 1'b1;
            mem_oe        <= 1'b0;
            mem_ReadWrite <= 1'b1;
            rsp0_valid    <= !curPort;
            rsp1_valid    <= curPort;
            state         <= IDLE;
          end
        end
        CAPTURE: begin
          if (curPort) begin
            rsp1_rdata <= mem_rdata;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_rdata <= mem_rdata;
            rsp0_valid <= 1'b1;
          end
          mem_nEnable <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
